// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine payout path.
package vend_pkg;

    localparam int AMT_W_DEF  = 5;
    localparam int CNT_W_DEF  = 6;
    localparam int ACK_TO_DEF = 15;

    localparam int COIN_1Y_UNITS = 2;
    localparam int COIN_05_UNITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SELECT,
        S_WAIT,
        S_DONE,
        S_ERR
    } vend_disp_state_t;

endpackage

// File: rtl/vend_ack_timer.sv
// Loadable down-counter with a terminal-count flag.
// Shared by the coin-accept and coin-payout paths.
module vend_ack_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Change payout: greedy 1-yuan then 5-jiao coins, one hopper-acked eject per coin.
// Optional VEND_COIN_INV_EN adds per-coin inventory counters and a feasibility check.
//
// state  | meaning
// IDLE   | ready for a change request
// CHECK  | zero / feasibility test on the latched amount
// SELECT | eject pulse for the chosen coin is on the output
// WAIT   | waiting for the hopper ack, ack timer running
// DONE   | one-cycle done pulse
// ERR    | insufficient change or jam, held until err_clr
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W  = AMT_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             disp_ack,
    output logic             coin1_out,
    output logic             coin05_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic [AMT_W-1:0] remaining
`ifdef VEND_COIN_INV_EN
    ,
    input  logic             inv_load,
    input  logic [CNT_W-1:0] inv_1y_in,
    input  logic [CNT_W-1:0] inv_05_in,
    output logic [CNT_W-1:0] inv_1y,
    output logic [CNT_W-1:0] inv_05
`endif
);

    localparam int TMR_W = $clog2(ACK_TO + 1);
    localparam int FW    = ((AMT_W > CNT_W) ? AMT_W : CNT_W) + 1;

    vend_disp_state_t state;
    logic             ready_q;
    logic             coin_is_1y;
    logic             accept;
    logic             tmr_expired;
    logic             feasible;
    logic             sel_1y_chk;
    logic             sel_1y_ack;
    logic [AMT_W-1:0] coin_units;
    logic [AMT_W-1:0] rem_after;
    logic [CNT_W-1:0] inv1_q;
    logic [CNT_W-1:0] inv05_q;
    logic [CNT_W-1:0] inv1_after;
    logic [FW-1:0]    amt_f;
    logic [FW-1:0]    half_f;
    logic [FW-1:0]    inv1_f;
    logic [FW-1:0]    use1_f;
    logic [FW-1:0]    rest_f;

`ifdef VEND_COIN_INV_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv1_q  <= '0;
            inv05_q <= '0;
        end else if (state == S_IDLE && inv_load) begin
            inv1_q  <= inv_1y_in;
            inv05_q <= inv_05_in;
        end else if (state == S_WAIT && disp_ack) begin
            if (coin_is_1y) inv1_q  <= inv1_q - 1'b1;
            else            inv05_q <= inv05_q - 1'b1;
        end
    end

    assign inv_1y     = inv1_q;
    assign inv_05     = inv05_q;
    assign inv1_after = coin_is_1y ? inv1_q - 1'b1 : inv1_q;
    // A same-cycle inventory load takes priority over a new request.
    assign req_ready  = ready_q & ~inv_load;
`else
    // Unlimited hopper: saturated counts make CHECK and the 1-yuan choice always pass.
    assign inv1_q     = '1;
    assign inv05_q    = '1;
    assign inv1_after = '1;
    assign req_ready  = ready_q;
`endif

    assign accept = req_valid & req_ready;

    // Greedy feasibility: use as many 1-yuan coins as possible, 5-jiao for the rest.
    assign amt_f    = FW'(remaining);
    assign half_f   = amt_f >> 1;
    assign inv1_f   = FW'(inv1_q);
    assign use1_f   = (inv1_f < half_f) ? inv1_f : half_f;
    assign rest_f   = amt_f - (use1_f << 1);
    assign feasible = (rest_f <= FW'(inv05_q));

    assign coin_units = coin_is_1y ? AMT_W'(COIN_1Y_UNITS) : AMT_W'(COIN_05_UNITS);
    assign rem_after  = remaining - coin_units;
    assign sel_1y_chk = (remaining >= AMT_W'(COIN_1Y_UNITS)) && (inv1_q != '0);
    assign sel_1y_ack = (rem_after >= AMT_W'(COIN_1Y_UNITS)) && (inv1_after != '0);

    // Loaded during SELECT so WAIT gives ACK_TO cycles for the ack.
    vend_ack_timer #(
        .W (TMR_W)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_SELECT),
        .en       (state == S_WAIT),
        .load_val (TMR_W'(ACK_TO - 1)),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ready_q    <= 1'b1;
            coin1_out  <= 1'b0;
            coin05_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            remaining  <= '0;
            coin_is_1y <= 1'b0;
        end else begin
            coin1_out  <= 1'b0;
            coin05_out <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        remaining <= req_amount;
                        ready_q   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (!feasible) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end else begin
                        coin_is_1y <= sel_1y_chk;
                        coin1_out  <= sel_1y_chk;
                        coin05_out <= ~sel_1y_chk;
                        state      <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (disp_ack) begin
                        remaining <= rem_after;
                        if (rem_after == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            coin_is_1y <= sel_1y_ack;
                            coin1_out  <= sel_1y_ack;
                            coin05_out <= ~sel_1y_ack;
                            state      <= S_SELECT;
                        end
                    end else if (tmr_expired) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_ERR;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                S_ERR: begin
                    if (err_clr) begin
                        err       <= 1'b0;
                        remaining <= '0;
                        ready_q   <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
